// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// then shifts one command byte (LSB first, odd parity, stop) out on the
// device-generated clock and checks the device ACK. Lines are driven as
// open-drain pull-downs through SCLK_OE/SDATA_OE.
// Optional build macro PS2_TX_RETRY_EN: one automatic retry after the first
// timeout or NACK before ERR is reported.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 2500,   // total cycles SCLK is held low (>= 2)
  parameter int START_TO    = 375000, // release-to-first-fall timeout
  parameter int XFER_TO     = 50000   // first-fall-to-idle timeout
) (
  input  logic       CLK,
  input  logic       ARST_L,
  input  logic [7:0] TXDATA,
  input  logic       TXSTART,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  input  logic       SCLK_IN,
  input  logic       SDATA_IN,
  output logic       SCLK_OE,
  output logic       SDATA_OE
);

  localparam int TW = $clog2(START_TO + 1);
  // INHIBIT lasts INHIBIT_CYC-1 cycles, REQ one more, so SCLK is low INHIBIT_CYC cycles
  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC - 2);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TO - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, WAITCLK, SHIFT, WAITIDLE, FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic            timer_clr;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [9:0]      frame_q;
  logic            load_frame;
  logic            sdata_oe_q, sdata_oe_d;
  logic [1:0]      idle_cnt_q;
  logic            fail_req;
  logic            done_pulse;
  logic            sclk_p0, sclk_p1, sclk_p2;
  logic            sdata_p0, sdata_p1;
  logic            fall;
`ifdef PS2_TX_RETRY_EN
  logic            retry_q;
`endif

  // Two-flop synchronisers for the raw line levels plus one delay for edge detect
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      sclk_p0  <= 1'b1;
      sclk_p1  <= 1'b1;
      sclk_p2  <= 1'b1;
      sdata_p0 <= 1'b1;
      sdata_p1 <= 1'b1;
    end else begin
      // stage boundary: p0 metastability catcher, p1 synced level, p2 previous level
      sclk_p0  <= SCLK_IN;
      sclk_p1  <= sclk_p0;
      sclk_p2  <= sclk_p1;
      sdata_p0 <= SDATA_IN;
      sdata_p1 <= sdata_p0;
    end
  end

  assign fall = sclk_p2 & ~sclk_p1;

  // State, timer, bit counter and data-line driver registers
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bitcnt_q   <= '0;
      sdata_oe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_clr ? '0 : timer_q + TW'(1);
      bitcnt_q   <= bitcnt_d;
      sdata_oe_q <= sdata_oe_d;
    end
  end

  // Frame capture: {stop, odd parity, data}; data-only register, no reset needed
  always_ff @(posedge CLK) begin
    if (load_frame) frame_q <= {1'b1, ~^TXDATA, TXDATA};
  end

  // Count consecutive cycles with both lines high while waiting for bus idle
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L)                      idle_cnt_q <= '0;
    else if (state_q != WAITIDLE)     idle_cnt_q <= '0;
    else if (!(sclk_p1 && sdata_p1))  idle_cnt_q <= '0;
    else if (idle_cnt_q != 2'd2)      idle_cnt_q <= idle_cnt_q + 2'd1;
  end

`ifdef PS2_TX_RETRY_EN
  // Remember that the single retry has been spent; cleared when the request ends
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L)                             retry_q <= 1'b0;
    else if (done_pulse || state_q == FAIL)  retry_q <= 1'b0;
    else if (fail_req)                       retry_q <= 1'b1;
  end
`endif

  // Next-state and datapath control; timeouts take priority over a coincident fall
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    sdata_oe_d = sdata_oe_q;
    load_frame = 1'b0;
    fail_req   = 1'b0;
    done_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        sdata_oe_d = 1'b0;
        if (TXSTART) begin
          load_frame = 1'b1;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        sdata_oe_d = 1'b0;
        if (timer_q == INH_LAST) begin
          sdata_oe_d = 1'b1;           // start bit
          state_d    = REQ;
        end
      end
      REQ: state_d = WAITCLK;
      WAITCLK: begin
        if (timer_q == START_LAST) begin
          fail_req = 1'b1;
        end else if (fall) begin
          sdata_oe_d = ~frame_q[0];
          bitcnt_d   = 4'd1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (timer_q == XFER_LAST) begin
          fail_req = 1'b1;
        end else if (fall) begin
          if (bitcnt_q == 4'd10) begin
            if (sdata_p1) fail_req = 1'b1;   // NACK
            else          state_d  = WAITIDLE;
          end else begin
            sdata_oe_d = ~frame_q[bitcnt_q];
            bitcnt_d   = bitcnt_q + 4'd1;
          end
        end
      end
      WAITIDLE: begin
        if (timer_q == XFER_LAST) begin
          fail_req = 1'b1;
        end else if (idle_cnt_q == 2'd2) begin
          done_pulse = 1'b1;
          state_d    = IDLE;
        end
      end
      FAIL: begin
        sdata_oe_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fail_req) begin
      sdata_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      state_d = retry_q ? FAIL : INHIBIT;
`else
      state_d = FAIL;
`endif
    end
  end

  // The transfer timer spans SHIFT and WAITIDLE, so that hand-over keeps counting
  assign timer_clr = (state_q == IDLE) ||
                     ((state_d != state_q) && !((state_q == SHIFT) && (state_d == WAITIDLE)));

  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_pulse;
  assign ERR      = (state_q == FAIL);
  assign SCLK_OE  = (state_q == INHIBIT) || (state_q == REQ);
  assign SDATA_OE = sdata_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on open-drain lines, a scoreboard
// queue of expected DONE/ERR outcomes and a monitor that checks each pulse.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int STO  = 200;
  localparam int XTO  = 250;
  localparam int HALF = 8;

  logic       CLK = 1'b0;
  logic       ARST_L;
  logic [7:0] TXDATA;
  logic       TXSTART;
  logic       BUSY, DONE, ERR;
  logic       SCLK_OE, SDATA_OE;
  logic       dev_clk, dev_data;
  logic       sclk_line, sdata_line;

  assign sclk_line  = dev_clk  & ~SCLK_OE;
  assign sdata_line = dev_data & ~SDATA_OE;

  ps2_host_tx #(.INHIBIT_CYC(INH), .START_TO(STO), .XFER_TO(XTO)) dut (
    .CLK(CLK), .ARST_L(ARST_L), .TXDATA(TXDATA), .TXSTART(TXSTART),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .SCLK_IN(sclk_line), .SDATA_IN(sdata_line),
    .SCLK_OE(SCLK_OE), .SDATA_OE(SDATA_OE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         is_done;
    logic [9:0] frame;
  } exp_t;
  exp_t sb[$];

  // ---------------- device model ----------------
  bit         dev_silent = 0;
  bit         dev_abort  = 0;
  bit         dev_busy   = 0;
  int         dev_nack   = 0;
  int         dev_falls  = 0;
  logic [9:0] dev_rx     = '0;

  task automatic run_frame();
    logic [9:0] rx;
    bit nack;
    rx = '0;
    nack = (dev_nack > 0);
    if (nack) dev_nack--;
    dev_falls = 0;
    repeat (HALF) @(negedge CLK);
    for (int k = 1; k <= 11; k++) begin
      if (dev_abort) break;
      dev_clk = 1'b0;
      dev_falls = k;
      repeat (HALF) @(negedge CLK);
      if (dev_abort) break;
      dev_clk = 1'b1;
      if (k <= 10) rx[k-1] = sdata_line;
      if (k == 10) begin
        dev_rx   = rx;
        dev_data = nack;   // 0 = ACK pulled low across fall 11
      end
      repeat (HALF) @(negedge CLK);
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  initial begin
    bit saw;
    saw = 0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    forever begin
      @(negedge CLK);
      if (!ARST_L) saw = 0;
      else if (SCLK_OE) saw = 1;
      else if (saw && SDATA_OE) begin
        saw = 0;
        if (!dev_silent) begin
          dev_busy = 1;
          run_frame();
          dev_busy = 0;
        end
      end else saw = 0;
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  bit   pend = 0;
  always @(posedge CLK) begin
    #1;
    if (ARST_L) begin
      if (pend) begin
        check("busy_after_pulse", BUSY, 1'b0);
        pend = 0;
      end
      if (DONE || ERR) begin
        pend = 1;
        check("pulse_exclusive", DONE & ERR, 1'b0);
        check("busy_at_pulse", BUSY, 1'b1);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: done=%b err=%b with no outcome queued", DONE, ERR);
        end else begin
          mon_e = sb.pop_front();
          check("outcome_is_done", DONE, mon_e.is_done);
          if (DONE) check("device_rx_frame", dev_rx, mon_e.frame);
        end
      end
    end else pend = 0;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    dev_falls = 0;
    @(negedge CLK);
    TXDATA  = b;
    TXSTART = 1'b1;
    @(negedge CLK);
    TXSTART = 1'b0;
    check("busy_after_accept", BUSY, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("end_within_budget", BUSY, 1'b0);
  endtask

  task automatic wait_falls(input int nf);
    int n;
    n = 0;
    while (dev_falls < nf && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check("reached_fall", (dev_falls >= nf), 1'b1);
  endtask

  task automatic wait_dev_free();
    int n;
    n = 0;
    while (dev_busy && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check("device_free", dev_busy, 1'b0);
  endtask

  initial begin
    int hi, n, last_rel, inh_cnt, err_cyc;
    bit prev;
    ARST_L  = 1'b0;
    TXDATA  = 8'h00;
    TXSTART = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_sclk_oe", SCLK_OE, 1'b0);
    check("rst_sdata_oe", SDATA_OE, 1'b0);
    ARST_L = 1'b1;
    repeat (5) @(negedge CLK);

    // 1: 0xED -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    sb.push_back('{1'b1, 10'h3ED});
    send(8'hED);
    hi = 0;
    while (SCLK_OE && hi < 1000) begin
      hi++;
      @(negedge CLK);
    end
    check("inhibit_len", hi, INH);
    wait_idle(2000);
    wait_dev_free();

    // 2: 0xF4 -> parity 0
    sb.push_back('{1'b1, 10'h2F4});
    send(8'hF4);
    wait_idle(2000);
    wait_dev_free();

    // 3: device never clocks -> ERR START_TO cycles after the last release
    dev_silent = 1;
    sb.push_back('{1'b0, 10'h000});
    send(8'h55);
    prev = SCLK_OE;
    last_rel = -1;
    inh_cnt = 0;
    err_cyc = -1;
    n = 0;
    while (n < 2000) begin
      @(negedge CLK);
      n++;
      if (prev && !SCLK_OE) begin
        last_rel = cyc;
        inh_cnt++;
      end
      prev = SCLK_OE;
      if (ERR) begin
        err_cyc = cyc;
        break;
      end
    end
    check("err_latency", err_cyc - last_rel, STO);
`ifdef PS2_TX_RETRY_EN
    check("inhibit_episodes", inh_cnt, 2);
`else
    check("inhibit_episodes", inh_cnt, 1);
`endif
    wait_idle(100);
    dev_silent = 0;
    repeat (5) @(negedge CLK);

    // 4: NACK on first attempt (0xA5 -> frame 3A5)
    dev_nack = 1;
`ifdef PS2_TX_RETRY_EN
    sb.push_back('{1'b1, 10'h3A5});
`else
    sb.push_back('{1'b0, 10'h000});
`endif
    send(8'hA5);
    wait_idle(3000);
    wait_dev_free();
    check("nack_consumed", dev_nack, 0);

    // 5: TXSTART mid-transfer and on the DONE cycle are ignored (0x0F -> 30F)
    sb.push_back('{1'b1, 10'h30F});
    send(8'h0F);
    wait_falls(3);
    @(negedge CLK);
    TXDATA  = 8'h00;
    TXSTART = 1'b1;
    @(negedge CLK);
    TXSTART = 1'b0;
    check("busy_held_mid", BUSY, 1'b1);
    n = 0;
    while (BUSY && n < 2000) begin
      @(negedge CLK);
      n++;
      TXSTART = DONE;
    end
    TXSTART = 1'b0;
    repeat (3) @(negedge CLK);
    check("txstart_on_done_ignored", BUSY | SCLK_OE, 1'b0);
    wait_dev_free();

    // 6: reset at fall 5 releases everything at once; next send works (0x5A -> 35A)
    send(8'hED);
    wait_falls(5);
    repeat (4) @(negedge CLK);
    check("sdata_bit4_driven", SDATA_OE, 1'b1);
    ARST_L = 1'b0;
    #1;
    check("arst_sclk_oe", SCLK_OE, 1'b0);
    check("arst_sdata_oe", SDATA_OE, 1'b0);
    check("arst_busy", BUSY, 1'b0);
    dev_abort = 1;
    wait_dev_free();
    dev_abort = 0;
    @(negedge CLK);
    ARST_L = 1'b1;
    repeat (5) @(negedge CLK);
    sb.push_back('{1'b1, 10'h35A});
    send(8'h5A);
    wait_idle(2000);
    wait_dev_free();
    repeat (5) @(negedge CLK);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
